// File: rtl/spr_writeback_sequencer.sv
// SPR writeback sequencer: shadows the SALU/VALU pipelines with SPR-write
// flags and pulses per-SPR write enables with the owning wavefront at retire.
//
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   salu_issue_*           SALU issue: valid, wfid, vcc/scc/exec/m0 write flags
//   valu_issue_*           VALU issue: valid, wfid, vcc write flag
//   flush_valid/_wfid      drop in-flight SPR writes of one wavefront
//   salu_wr_*              SALU retire: wfid (0 when idle) and per-SPR enables
//   valu_wr_vcc_*          VALU retire: wfid (0 when idle) and VCC enable
//   pending_cnt, idle      in-flight entries carrying at least one write flag
module spr_writeback_sequencer #(
    parameter int WFID_W   = 6,
    parameter int SALU_LAT = 4,
    parameter int VALU_LAT = 8,
    parameter int CNT_W    = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              salu_issue_valid,
    input  logic [WFID_W-1:0] salu_issue_wfid,
    input  logic              salu_issue_vcc_wr,
    input  logic              salu_issue_scc_wr,
    input  logic              salu_issue_exec_wr,
    input  logic              salu_issue_m0_wr,
    input  logic              valu_issue_valid,
    input  logic [WFID_W-1:0] valu_issue_wfid,
    input  logic              valu_issue_vcc_wr,
    input  logic              flush_valid,
    input  logic [WFID_W-1:0] flush_wfid,
    output logic [WFID_W-1:0] salu_wr_wfid,
    output logic              salu_wr_vcc_en,
    output logic              salu_wr_scc_en,
    output logic              salu_wr_exec_en,
    output logic              salu_wr_m0_en,
    output logic [WFID_W-1:0] valu_wr_vcc_wfid,
    output logic              valu_wr_vcc_en,
    output logic [CNT_W-1:0]  pending_cnt,
    output logic              idle
);

    // SALU flag vector bit positions
    localparam int F_VCC  = 0;
    localparam int F_SCC  = 1;
    localparam int F_EXEC = 2;
    localparam int F_M0   = 3;

    localparam int SL = SALU_LAT - 1;
    localparam int VL = VALU_LAT - 1;

    // SALU shadow pipe; stage SL is the registered output stage
    logic              r_s_vld  [SALU_LAT];
    logic [WFID_W-1:0] r_s_wfid [SALU_LAT];
    logic [3:0]        r_s_flg  [SALU_LAT];

    // VALU shadow pipe; stage VL is the registered output stage
    logic              r_v_vld  [VALU_LAT];
    logic [WFID_W-1:0] r_v_wfid [VALU_LAT];
    logic              r_v_vcc  [VALU_LAT];

    logic [CNT_W-1:0]  r_cnt;
    logic              r_idle;

    logic              w_s_vld_nxt  [SALU_LAT];
    logic [WFID_W-1:0] w_s_wfid_nxt [SALU_LAT];
    logic [3:0]        w_s_flg_nxt  [SALU_LAT];
    logic              w_v_vld_nxt  [VALU_LAT];
    logic [WFID_W-1:0] w_v_wfid_nxt [VALU_LAT];
    logic              w_v_vcc_nxt  [VALU_LAT];

    logic [3:0]        w_s_flg_in;
    logic              w_v_vcc_in;
    logic              w_s_kill;
    logic              w_v_kill;
    logic [CNT_W-1:0]  w_enter;
    logic [CNT_W-1:0]  w_leave;
    logic [CNT_W-1:0]  w_flushed;
    logic [CNT_W-1:0]  w_cnt_nxt;

    // SALU next-state: stage 0 takes the issue (never flushed, it is newer
    // than the flush); inner stages shift and drop flags of the flushed
    // wavefront. The output stage is not examined: it is already presented.
    // wfid is zeroed whenever no flag survives so retire outputs read 0.
    always_comb begin
        w_s_flg_in = '0;
        if (salu_issue_valid) begin
            w_s_flg_in[F_VCC]  = salu_issue_vcc_wr;
            w_s_flg_in[F_SCC]  = salu_issue_scc_wr;
            w_s_flg_in[F_EXEC] = salu_issue_exec_wr;
            w_s_flg_in[F_M0]   = salu_issue_m0_wr;
        end
        w_s_vld_nxt[0]  = salu_issue_valid;
        w_s_flg_nxt[0]  = w_s_flg_in;
        w_s_wfid_nxt[0] = (|w_s_flg_in) ? salu_issue_wfid : '0;
        w_s_kill        = 1'b0;
        for (int i = 1; i < SALU_LAT; i++) begin
            w_s_kill = flush_valid && r_s_vld[i-1] &&
                       (r_s_wfid[i-1] == flush_wfid);
            w_s_vld_nxt[i]  = r_s_vld[i-1];
            w_s_flg_nxt[i]  = w_s_kill ? 4'b0000 : r_s_flg[i-1];
            w_s_wfid_nxt[i] = (|w_s_flg_nxt[i]) ? r_s_wfid[i-1] : '0;
        end
    end

    // VALU next-state, same scheme with a single VCC flag
    always_comb begin
        w_v_vcc_in      = valu_issue_valid & valu_issue_vcc_wr;
        w_v_vld_nxt[0]  = valu_issue_valid;
        w_v_vcc_nxt[0]  = w_v_vcc_in;
        w_v_wfid_nxt[0] = w_v_vcc_in ? valu_issue_wfid : '0;
        w_v_kill        = 1'b0;
        for (int i = 1; i < VALU_LAT; i++) begin
            w_v_kill = flush_valid && r_v_vld[i-1] &&
                       (r_v_wfid[i-1] == flush_wfid);
            w_v_vld_nxt[i]  = r_v_vld[i-1];
            w_v_vcc_nxt[i]  = r_v_vcc[i-1] & ~w_v_kill;
            w_v_wfid_nxt[i] = w_v_vcc_nxt[i] ? r_v_wfid[i-1] : '0;
        end
    end

    // Pending count bookkeeping. Only entries with at least one flag are
    // counted; an entry flushed out of an inner stage is subtracted once
    // and then never seen leaving, so the count cannot underflow.
    always_comb begin
        w_enter = CNT_W'(|w_s_flg_in) + CNT_W'(w_v_vcc_in);
        w_leave = CNT_W'(r_s_vld[SL] & (|r_s_flg[SL])) +
                  CNT_W'(r_v_vld[VL] & r_v_vcc[VL]);
        w_flushed = '0;
        for (int i = 0; i < SL; i++) begin
            if (flush_valid && r_s_vld[i] && (|r_s_flg[i]) &&
                (r_s_wfid[i] == flush_wfid)) begin
                w_flushed = w_flushed + CNT_W'(1);
            end
        end
        for (int i = 0; i < VL; i++) begin
            if (flush_valid && r_v_vld[i] && r_v_vcc[i] &&
                (r_v_wfid[i] == flush_wfid)) begin
                w_flushed = w_flushed + CNT_W'(1);
            end
        end
        w_cnt_nxt = r_cnt + w_enter - w_leave - w_flushed;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SALU_LAT; i++) begin
                r_s_vld[i]  <= 1'b0;
                r_s_wfid[i] <= '0;
                r_s_flg[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < SALU_LAT; i++) begin
                r_s_vld[i]  <= w_s_vld_nxt[i];
                r_s_wfid[i] <= w_s_wfid_nxt[i];
                r_s_flg[i]  <= w_s_flg_nxt[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < VALU_LAT; i++) begin
                r_v_vld[i]  <= 1'b0;
                r_v_wfid[i] <= '0;
                r_v_vcc[i]  <= 1'b0;
            end
        end else begin
            for (int i = 0; i < VALU_LAT; i++) begin
                r_v_vld[i]  <= w_v_vld_nxt[i];
                r_v_wfid[i] <= w_v_wfid_nxt[i];
                r_v_vcc[i]  <= w_v_vcc_nxt[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= '0;
            r_idle <= 1'b1;
        end else begin
            r_cnt  <= w_cnt_nxt;
            r_idle <= (w_cnt_nxt == '0);
        end
    end

    // Retire outputs come straight from the last pipeline registers
    assign salu_wr_wfid     = r_s_wfid[SL];
    assign salu_wr_vcc_en   = r_s_vld[SL] & r_s_flg[SL][F_VCC];
    assign salu_wr_scc_en   = r_s_vld[SL] & r_s_flg[SL][F_SCC];
    assign salu_wr_exec_en  = r_s_vld[SL] & r_s_flg[SL][F_EXEC];
    assign salu_wr_m0_en    = r_s_vld[SL] & r_s_flg[SL][F_M0];
    assign valu_wr_vcc_wfid = r_v_wfid[VL];
    assign valu_wr_vcc_en   = r_v_vld[VL] & r_v_vcc[VL];
    assign pending_cnt      = r_cnt;
    assign idle             = r_idle;

endmodule

// File: tb/tb_spr_writeback_sequencer.sv
// Directed bench for spr_writeback_sequencer: retire timing, dual retire,
// back-to-back issue, flush, flagless issue and asynchronous reset.
module tb_spr_writeback_sequencer;

    localparam int WFID_W = 6;
    localparam int CNT_W  = 5;

    localparam logic [3:0] VCC  = 4'b0001;
    localparam logic [3:0] SCC  = 4'b0010;
    localparam logic [3:0] EXEC = 4'b0100;
    localparam logic [3:0] M0   = 4'b1000;

    logic              clk = 1'b0;
    logic              rst;
    logic              salu_issue_valid;
    logic [WFID_W-1:0] salu_issue_wfid;
    logic              salu_issue_vcc_wr;
    logic              salu_issue_scc_wr;
    logic              salu_issue_exec_wr;
    logic              salu_issue_m0_wr;
    logic              valu_issue_valid;
    logic [WFID_W-1:0] valu_issue_wfid;
    logic              valu_issue_vcc_wr;
    logic              flush_valid;
    logic [WFID_W-1:0] flush_wfid;
    logic [WFID_W-1:0] salu_wr_wfid;
    logic              salu_wr_vcc_en;
    logic              salu_wr_scc_en;
    logic              salu_wr_exec_en;
    logic              salu_wr_m0_en;
    logic [WFID_W-1:0] valu_wr_vcc_wfid;
    logic              valu_wr_vcc_en;
    logic [CNT_W-1:0]  pending_cnt;
    logic              idle;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    spr_writeback_sequencer #(
        .WFID_W  (WFID_W),
        .SALU_LAT(4),
        .VALU_LAT(8),
        .CNT_W   (CNT_W)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .salu_issue_valid  (salu_issue_valid),
        .salu_issue_wfid   (salu_issue_wfid),
        .salu_issue_vcc_wr (salu_issue_vcc_wr),
        .salu_issue_scc_wr (salu_issue_scc_wr),
        .salu_issue_exec_wr(salu_issue_exec_wr),
        .salu_issue_m0_wr  (salu_issue_m0_wr),
        .valu_issue_valid  (valu_issue_valid),
        .valu_issue_wfid   (valu_issue_wfid),
        .valu_issue_vcc_wr (valu_issue_vcc_wr),
        .flush_valid       (flush_valid),
        .flush_wfid        (flush_wfid),
        .salu_wr_wfid      (salu_wr_wfid),
        .salu_wr_vcc_en    (salu_wr_vcc_en),
        .salu_wr_scc_en    (salu_wr_scc_en),
        .salu_wr_exec_en   (salu_wr_exec_en),
        .salu_wr_m0_en     (salu_wr_m0_en),
        .valu_wr_vcc_wfid  (valu_wr_vcc_wfid),
        .valu_wr_vcc_en    (valu_wr_vcc_en),
        .pending_cnt       (pending_cnt),
        .idle              (idle)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clr_in();
        salu_issue_valid   = 1'b0;
        salu_issue_wfid    = '0;
        salu_issue_vcc_wr  = 1'b0;
        salu_issue_scc_wr  = 1'b0;
        salu_issue_exec_wr = 1'b0;
        salu_issue_m0_wr   = 1'b0;
        valu_issue_valid   = 1'b0;
        valu_issue_wfid    = '0;
        valu_issue_vcc_wr  = 1'b0;
        flush_valid        = 1'b0;
        flush_wfid         = '0;
    endtask

    // Start a new cycle: inputs change 1ns after the rising edge
    task automatic cyc();
        @(posedge clk);
        #1;
        clr_in();
    endtask

    task automatic s_iss(input int w, input logic [3:0] f);
        salu_issue_valid   = 1'b1;
        salu_issue_wfid    = WFID_W'(w);
        salu_issue_vcc_wr  = f[0];
        salu_issue_scc_wr  = f[1];
        salu_issue_exec_wr = f[2];
        salu_issue_m0_wr   = f[3];
    endtask

    task automatic v_iss(input int w);
        valu_issue_valid  = 1'b1;
        valu_issue_wfid   = WFID_W'(w);
        valu_issue_vcc_wr = 1'b1;
    endtask

    task automatic flush(input int w);
        flush_valid = 1'b1;
        flush_wfid  = WFID_W'(w);
    endtask

    // Compare every output now; sf is {m0,exec,scc,vcc}
    task automatic snap(input string tag, input logic [3:0] sf,
                        input int sw, input logic ve, input int vw,
                        input int cnt);
        check({tag, ":s_en"},
              32'({salu_wr_m0_en, salu_wr_exec_en,
                   salu_wr_scc_en, salu_wr_vcc_en}), 32'(sf));
        check({tag, ":s_wfid"}, 32'(salu_wr_wfid), 32'(sw));
        check({tag, ":v_en"}, 32'(valu_wr_vcc_en), 32'(ve));
        check({tag, ":v_wfid"}, 32'(valu_wr_vcc_wfid), 32'(vw));
        check({tag, ":cnt"}, 32'(pending_cnt), 32'(cnt));
        check({tag, ":idle"}, 32'(idle), 32'(cnt == 0));
    endtask

    task automatic obs(input string tag, input logic [3:0] sf,
                       input int sw, input logic ve, input int vw,
                       input int cnt);
        @(negedge clk);
        snap(tag, sf, sw, ve, vw, cnt);
    endtask

    int exp_cnt3 [13] = '{0, 1, 2, 3, 4, 4, 4, 4, 4, 3, 2, 1, 0};
    int exp_c4   [8]  = '{0, 1, 2, 2, 2, 2, 1, 0};
    int hits;

    initial begin
        rst = 1'b1;
        clr_in();
        repeat (2) @(posedge clk);
        #1;
        obs("reset", 4'b0, 0, 1'b0, 0, 0);
        cyc();
        rst = 1'b0;
        obs("release", 4'b0, 0, 1'b0, 0, 0);

        // 1: single SALU issue, retire 4 cycles later
        cyc(); s_iss(5, SCC | EXEC);
        obs("t1c0", 4'b0, 0, 1'b0, 0, 0);
        for (int c = 1; c < 4; c++) begin
            cyc();
            obs("t1wait", 4'b0, 0, 1'b0, 0, 1);
        end
        cyc(); obs("t1ret", SCC | EXEC, 5, 1'b0, 0, 1);
        cyc(); obs("t1end", 4'b0, 0, 1'b0, 0, 0);

        // 2: VALU and SALU VCC retire in the same cycle
        cyc(); v_iss(12);
        obs("t2c0", 4'b0, 0, 1'b0, 0, 0);
        for (int c = 1; c < 8; c++) begin
            cyc();
            if (c == 4) s_iss(12, VCC);
            obs("t2wait", 4'b0, 0, 1'b0, 0, (c > 4) ? 2 : 1);
        end
        cyc(); obs("t2ret", VCC, 12, 1'b1, 12, 2);
        cyc(); obs("t2end", 4'b0, 0, 1'b0, 0, 0);

        // 3: back-to-back SALU issues wfid 1..8
        for (int c = 0; c < 13; c++) begin
            cyc();
            if (c < 8) s_iss(c + 1, SCC);
            if (c >= 4 && c < 12)
                obs("t3ret", SCC, c - 3, 1'b0, 0, exp_cnt3[c]);
            else
                obs("t3", 4'b0, 0, 1'b0, 0, exp_cnt3[c]);
        end

        // 4: flush wfid 3 with a same-cycle wfid 3 issue; wfid 7 survives
        for (int c = 0; c < 8; c++) begin
            cyc();
            if (c == 0) s_iss(3, M0);
            if (c == 1) s_iss(7, EXEC);
            if (c == 2) begin
                flush(3);
                s_iss(3, M0);
            end
            if (c == 5)
                obs("t4w7", EXEC, 7, 1'b0, 0, exp_c4[c]);
            else if (c == 6)
                obs("t4w3", M0, 3, 1'b0, 0, exp_c4[c]);
            else
                obs("t4", 4'b0, 0, 1'b0, 0, exp_c4[c]);
        end

        // 4b: VALU flush in an inner stage vs in the output stage
        for (int c = 0; c < 11; c++) begin
            cyc();
            if (c == 0) v_iss(20);
            if (c == 1) v_iss(21);
            if (c == 7) flush(20);
            if (c == 9) flush(21);
            if (c == 9)
                obs("t4b_out", 4'b0, 0, 1'b1, 21, 1);
            else
                obs("t4b", 4'b0, 0, 1'b0, 0,
                    (c == 0 || c == 10) ? 0 :
                    (c == 1 || c == 8) ? 1 : 2);
        end

        // 5: valid issue with no write flags
        cyc(); s_iss(9, 4'b0000);
        obs("t5c0", 4'b0, 0, 1'b0, 0, 0);
        for (int c = 1; c < 6; c++) begin
            cyc();
            obs("t5", 4'b0, 0, 1'b0, 0, 0);
        end

        // 6: fill both pipes, then asynchronous reset mid-cycle
        for (int c = 0; c < 6; c++) begin
            cyc();
            s_iss(c + 10, VCC | M0);
            v_iss(c + 30);
            if (c == 4)
                obs("t6c4", VCC | M0, 10, 1'b0, 0, 8);
            else if (c == 5)
                obs("t6c5", VCC | M0, 11, 1'b0, 0, 9);
        end
        #2;
        rst = 1'b1;
        #1;
        snap("t6rst", 4'b0, 0, 1'b0, 0, 0);
        cyc();
        cyc();
        rst = 1'b0;
        hits = 0;
        for (int c = 0; c < 12; c++) begin
            cyc();
            @(negedge clk);
            if (salu_wr_vcc_en || salu_wr_scc_en || salu_wr_exec_en ||
                salu_wr_m0_en || valu_wr_vcc_en || pending_cnt != 0)
                hits++;
        end
        check("t6post_pulses", 32'(hits), 32'd0);
        snap("t6end", 4'b0, 0, 1'b0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
